// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, ctl/flag bit positions and controller state encoding
package alu_pkg;

  localparam logic [3:0] OP_NONE   = 4'b0000;
  localparam logic [3:0] OP_AND    = 4'b0011;
  localparam logic [3:0] OP_OR     = 4'b0100;
  localparam logic [3:0] OP_XOR    = 4'b0101;
  localparam logic [3:0] OP_ADD    = 4'b0110;
  localparam logic [3:0] OP_CMP    = 4'b0111;
  localparam logic [3:0] OP_ROL    = 4'b1000;
  localparam logic [3:0] OP_SLL    = 4'b1001;
  localparam logic [3:0] OP_ROR    = 4'b1010;
  localparam logic [3:0] OP_SRL    = 4'b1011;
  localparam logic [3:0] OP_INV    = 4'b1100;
  localparam logic [3:0] OP_BYPASS = 4'b1101;

  // ctl = {SLBIshift8, NegA, InvB, ALUOperation[3:0]}
  localparam int CTL_SLBI   = 6;
  localparam int CTL_NEGA   = 5;
  localparam int CTL_INVB   = 4;
  localparam int CTL_OP_MSB = 3;

  // flags = {SF, ZF, OF, CF}
  localparam int FLG_SF = 3;
  localparam int FLG_ZF = 2;
  localparam int FLG_OF = 1;
  localparam int FLG_CF = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_has_result(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_ADD,
      OP_ROL, OP_SLL, OP_ROR, OP_SRL,
      OP_INV, OP_BYPASS: op_has_result = 1'b1;
      default:           op_has_result = 1'b0;
    endcase
  endfunction

  // Anything other than a clean 1 (0, X, Z) is stored as 0.
  function automatic logic clean_bit(input logic b);
    clean_bit = (b === 1'b1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; on a tie the port that was not granted last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       winner,
  output logic       any
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
    winner = gnt[1];
    any    = |req;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one ALU between two requesters, one operation in flight
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int EXEC_LAT = 1,
  parameter int W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_oprA,
  input  logic [W-1:0] req0_oprB,
  input  logic [6:0]   req0_ctl,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_oprA,
  input  logic [W-1:0] req1_oprB,
  input  logic [6:0]   req1_ctl,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [W-1:0] resp_out,
  output logic [3:0]   resp_flags,
  output logic [W-1:0] alu_oprA,
  output logic [W-1:0] alu_oprB,
  output logic [3:0]   alu_op,
  output logic         alu_slbi,
  output logic         alu_nega,
  output logic         alu_invb,
  input  logic [W-1:0] alu_out,
  input  logic         alu_sf,
  input  logic         alu_zf,
  input  logic         alu_of,
  input  logic         alu_cf
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_LAT - 1);

  state_e       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         grant_q, grant_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [W-1:0] opr_a_q, opr_a_d;
  logic [W-1:0] opr_b_q, opr_b_d;
  logic [6:0]   ctl_q, ctl_d;
  logic [W-1:0] resp_out_q, resp_out_d;
  logic [3:0]   resp_flags_q, resp_flags_d;

  logic [1:0]   arb_gnt;
  logic         arb_winner;
  logic         arb_any;

  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .winner     (arb_winner),
    .any        (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      opr_a_q      <= '0;
      opr_b_q      <= '0;
      ctl_q        <= '0;
      resp_out_q   <= '0;
      resp_flags_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      opr_a_q      <= opr_a_d;
      opr_b_q      <= opr_b_d;
      ctl_q        <= ctl_d;
      resp_out_q   <= resp_out_d;
      resp_flags_q <= resp_flags_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    opr_a_d      = opr_a_q;
    opr_b_d      = opr_b_q;
    ctl_d        = ctl_q;
    resp_out_d   = resp_out_q;
    resp_flags_d = resp_flags_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          opr_a_d = arb_winner ? req1_oprA : req0_oprA;
          opr_b_d = arb_winner ? req1_oprB : req0_oprB;
          ctl_d   = arb_winner ? req1_ctl  : req0_ctl;
          grant_d = arb_winner;
          cnt_d   = CNT_INIT;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_out_d = op_has_result(ctl_q[CTL_OP_MSB:0]) ? alu_out : '0;
          resp_flags_d = '0;
          if (ctl_q[CTL_OP_MSB:0] != OP_NONE) begin
            resp_flags_d[FLG_SF] = clean_bit(alu_sf);
            resp_flags_d[FLG_ZF] = clean_bit(alu_zf);
            resp_flags_d[FLG_OF] = clean_bit(alu_of);
            resp_flags_d[FLG_CF] = clean_bit(alu_cf);
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (grant_q ? resp1_ready : resp0_ready) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is gated by rst so nothing looks accepted during a reset cycle.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    alu_oprA    = '0;
    alu_oprB    = '0;
    alu_op      = OP_NONE;
    alu_slbi    = 1'b0;
    alu_nega    = 1'b0;
    alu_invb    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = !rst && arb_gnt[0];
        req1_ready = !rst && arb_gnt[1];
      end
      ST_EXEC: begin
        alu_oprA = opr_a_q;
        alu_oprB = opr_b_q;
        alu_op   = ctl_q[CTL_OP_MSB:0];
        alu_slbi = ctl_q[CTL_SLBI];
        alu_nega = ctl_q[CTL_NEGA];
        alu_invb = ctl_q[CTL_INVB];
      end
      ST_RESP: begin
        resp0_valid = !grant_q;
        resp1_valid = grant_q;
      end
      default: ;
    endcase
  end

  assign resp_out   = resp_out_q;
  assign resp_flags = resp_flags_q;

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Multi-cycle controller that shares the single 16-bit ALU between two requesters: port 0 (execute stage) and port 1 (auxiliary address/branch unit).
- Arbitrates between the two requesters round-robin and latches the granted operands and control.
- Drives the ALU for a configurable number of cycles, captures the result and the {SF,ZF,OF,CF} flags, and returns them to the granted requester over a valid/ready handshake.
- Only one operation is in flight at a time.

Parameters:
- EXEC_LAT, 1, cycles the ALU inputs are held stable before capture (legal range 1..15).
- W, 16, datapath width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request N has an operation (N = 0, 1).
- reqN_ready  out  1  request N accepted this cycle.
- reqN_oprA  in  W  operand A.
- reqN_oprB  in  W  operand B.
- reqN_ctl  in  7  {SLBIshift8, NegA, InvB, ALUOperation[3:0]}.
- respN_valid  out  1  result for requester N available.
- respN_ready  in  1  requester N consumes the result.
- resp_out  out  W  captured result, shared by both response ports.
- resp_flags  out  4  captured {SF,ZF,OF,CF}.
- alu_oprA, alu_oprB  out  W  to ALU.
- alu_op  out  4  to ALU.
- alu_slbi, alu_nega, alu_invb  out  1 each  to ALU.
- alu_out  in  W  from ALU.
- alu_sf, alu_zf, alu_of, alu_cf  in  1 each  from ALU.

Behaviour:
- Reset values (rst sampled high at a clk edge): state = IDLE, last_grant = 1, cnt = 0, all ready/valid outputs 0, resp_out = 0, resp_flags = 0, alu_op = 4'b0000 (NONE), all other alu_* outputs 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational and asserted only for the arbiter winner.
  - Winner: if both requests are valid, the port != last_grant wins. Otherwise the single valid port wins.
  - On accept: latch oprA, oprB and ctl; set grant = winner; cnt = EXEC_LAT-1; go to EXEC.
  - With no valid request, stay in IDLE with alu_op = NONE.
- EXEC:
  - alu_* outputs are driven from the latched request registers.
  - While cnt != 0, decrement cnt.
  - When cnt == 0: capture the result and flags, go to RESP.
- Capture rules:
  - resp_out = alu_out, except force 0 when op is NONE (0000), CMP (0111), or any code not in {0011,0100,0101,0110,1000,1001,1010,1011,1100,1101}.
  - resp_flags = {alu_sf, alu_zf, alu_of, alu_cf}, forced to 0 when op = NONE.
  - Any X/Z on the captured flags is stored as 0.
- RESP:
  - resp<grant>_valid = 1; the other respN_valid = 0.
  - resp_out and resp_flags are held stable.
  - When resp<grant>_ready is seen: last_grant = grant, go to IDLE.
  - The next request is accepted no earlier than the following cycle.
- Latency: accept at cycle T → respN_valid at T+1+EXEC_LAT. Minimum issue interval is 2+EXEC_LAT cycles.
- Backpressure:
  - No new accept while in EXEC or RESP; both reqN_ready are 0.
  - reqN_valid held by a requester stays pending and must not be dropped by this block.
- Reset mid-operation: the operation is abandoned, no response is issued, and all outputs take their reset values on the next cycle.
- Fairness: alternating grants when both requests are continuously valid; neither port waits more than one full transaction.
- A request arriving in the same cycle that RESP completes is not accepted until IDLE.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants: NONE 0000, ADD 0110, XOR 0101, AND 0011, OR 0100, CMP 0111, ROL 1000, SLL 1001, ROR 1010, SRL 1011, INV 1100, BYPASS 1101.
  - Ctl bit indices.
  - Flag bit order {SF,ZF,OF,CF}.
  - FSM state encoding.
- One sub-module is natural: rr_arb2, the 2-way round-robin grant logic with a last_grant input.

Test Plan:
- Arbitration after reset, EXEC_LAT = 1: both ports request in the same cycle.
  - Port 0 asks ADD 0x0003 + 0x0004. Port 1 asks XOR 0x00FF ^ 0x0F0F.
  - Required: port 0 is accepted first; resp0_valid 2 cycles later with resp_out = 0x0007, flags = 0000.
  - Then port 1 is accepted, with resp_out = 0x0FF0, flags = 0000.
- CMP: ctl NegA = 1, op 0111, A = 0x0005, B = 0x0005 → resp_out = 0x0000, flags = 0101 (ZF = 1, CF = 1).
- Backpressure: resp0_ready held low for 3 cycles with req1_valid high.
  - Required: resp0_valid, resp_out and resp_flags stable throughout; req1_ready stays 0.
  - Port 1 is accepted the cycle after the handshake completes.
- EXEC_LAT = 4, SLL A = 0x0001, B = 0x0004 → resp_out = 0x0010 at exactly T+5 after accept.
- Reset asserted in EXEC → no respN_valid; all outputs at reset values next cycle.
  - A fresh request is then accepted from IDLE, and port 0 wins a tie.
- Unknown op 1110 and op NONE → resp_out = 0x0000.
  - op 1110: flags taken from the ALU with X/Z stored as 0.
  - op NONE: flags = 0000.
